// File: rtl/final_top_accel.sv
// final_top_accel: AHB-Lite subordinate around an 8x8 int8 matrix-multiply
// engine computing OUT = act(X*W + bias), one output row per 9 cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for LOAD_W or START
// S_LOADW   | copying one weight-buffer row per cycle into active array
// S_ROW_MAC | accumulating X[row][k]*W[k][j] for k = 0..N-1, all lanes
// S_ROW_WB  | bias + activation + saturation, store output row
// S_DONE    | one idle cycle after the last row; accepts commands
module final_top_accel #(
   parameter int N     = 8,
   parameter int ACC_W = 24
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        hsel,
   input  logic [7:0]  haddr,
   input  logic [1:0]  htrans,
   input  logic [2:0]  hsize,
   input  logic        hwrite,
   input  logic [63:0] hwdata,
   input  logic [2:0]  hburst,
   output logic [63:0] hrdata,
   output logic        hresp,
   output logic        hready
);

   localparam int PW = $clog2(N);

   localparam logic [7:0] A_WEIGHT = 8'h00;
   localparam logic [7:0] A_INPUT  = 8'h08;
   localparam logic [7:0] A_BIAS   = 8'h10;
   localparam logic [7:0] A_OUTPUT = 8'h18;
   localparam logic [7:0] A_STATUS = 8'h20;
   localparam logic [7:0] A_CTRL   = 8'h22;
   localparam logic [7:0] A_ACT    = 8'h24;

   localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOADW,
      S_ROW_MAC,
      S_ROW_WB,
      S_DONE
   } state_t;

   // bus data-phase state
   logic          dp_valid_q, dp_write_q, err2_q;
   logic [7:0]    dp_addr_q;
   logic [2:0]    dp_size_q;

   // register file and buffers
   logic [63:0]   wbuf_q [N];
   logic [63:0]   ibuf_q [N];
   logic [63:0]   wact_q [N];
   logic [63:0]   obuf_q [N];
   logic [63:0]   bias_q;
   logic [1:0]    mode_q;
   logic [PW-1:0] wwp_q, iwp_q, rp_q;
   logic          out_valid_q;

   // compute engine
   state_t                   state_q, state_d;
   logic [PW-1:0]            k_q, k_d, row_q, row_d;
   logic signed [ACC_W-1:0]  acc_q [N];
   logic signed [ACC_W-1:0]  acc_d [N];
   logic signed [15:0]       prod [N];
   logic signed [7:0]        x_k;
   logic [63:0]              wb_row;
   logic                     ld_en, mac_en, wb_en, done_pulse, busy;

   // decode
   logic hit_w, hit_in, hit_b, hit_o, hit_st, hit_ct, hit_am;
   logic row_reg, byte_reg, bad, dp_err, dp_ok, wr_ok, rd_ok;
   logic cmd_load, cmd_start;
   logic [7:0] wbyte;

   logic unused_bits;
   assign unused_bits = ^{hburst, htrans[0]};

   assign hit_w    = (dp_addr_q == A_WEIGHT);
   assign hit_in   = (dp_addr_q == A_INPUT);
   assign hit_b    = (dp_addr_q == A_BIAS);
   assign hit_o    = (dp_addr_q == A_OUTPUT);
   assign hit_st   = (dp_addr_q == A_STATUS);
   assign hit_ct   = (dp_addr_q == A_CTRL);
   assign hit_am   = (dp_addr_q == A_ACT);
   assign row_reg  = hit_w | hit_in | hit_b | hit_o;
   assign byte_reg = hit_st | hit_ct | hit_am;

   assign bad = ~(row_reg | byte_reg)
              | (row_reg  & (dp_size_q != 3'd3))
              | (byte_reg & (dp_size_q != 3'd0))
              | ( dp_write_q & (hit_o | hit_st))
              | (~dp_write_q & (hit_w | hit_in))
              | ( dp_write_q & busy & (hit_w | hit_in | hit_b | hit_ct))
              | (~dp_write_q & busy & hit_o);

   assign dp_err = dp_valid_q & bad;
   assign dp_ok  = dp_valid_q & ~bad;
   assign wr_ok  = dp_ok & dp_write_q;
   assign rd_ok  = dp_ok & ~dp_write_q;

   assign wbyte     = hwdata[{dp_addr_q[2:0], 3'b000} +: 8];
   assign cmd_load  = wr_ok & hit_ct & (wbyte == 8'd2);
   assign cmd_start = wr_ok & hit_ct & (wbyte == 8'd1);

   // first error cycle stalls, second completes; both flag ERROR
   assign hready = ~dp_err;
   assign hresp  = dp_err | err2_q;

   assign busy = (state_q == S_LOADW) | (state_q == S_ROW_MAC) | (state_q == S_ROW_WB);

   // capture address-phase fields of each accepted transfer
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_addr_q  <= '0;
         dp_size_q  <= '0;
         err2_q     <= 1'b0;
      end else begin
         err2_q <= dp_err;
         if (hready) begin
            dp_valid_q <= hsel & htrans[1];
            dp_addr_q  <= haddr;
            dp_write_q <= hwrite;
            dp_size_q  <= hsize;
         end else begin
            dp_valid_q <= 1'b0;
         end
      end
   end

   // read data mux, lane-aligned for byte registers
   always_comb begin
      hrdata = '0;
      if (rd_ok) begin
         if (hit_b)       hrdata = bias_q;
         else if (hit_o)  hrdata = obuf_q[rp_q];
         else if (hit_st) hrdata = {62'b0, out_valid_q, busy};
         else if (hit_am) hrdata = {30'b0, mode_q, 32'b0};
      end
   end

   // bus-written buffers, pointers and configuration
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         for (int i = 0; i < N; i++) begin
            wbuf_q[i] <= '0;
            ibuf_q[i] <= '0;
         end
         wwp_q  <= '0;
         iwp_q  <= '0;
         rp_q   <= '0;
         bias_q <= '0;
         mode_q <= '0;
      end else begin
         if (wr_ok & hit_w) begin
            wbuf_q[wwp_q] <= hwdata;
            wwp_q         <= wwp_q + 1'b1;
         end
         if (cmd_load) wwp_q <= '0;
         if (wr_ok & hit_in) begin
            ibuf_q[iwp_q] <= hwdata;
            iwp_q         <= iwp_q + 1'b1;
         end
         if (wr_ok & hit_b)  bias_q <= hwdata;
         if (wr_ok & hit_am) mode_q <= wbyte[1:0];
         if (rd_ok & hit_o)  rp_q   <= rp_q + 1'b1;
         if (done_pulse) begin
            iwp_q <= '0;
            rp_q  <= '0;
         end
      end
   end

   // compute FSM state and counters
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         row_q   <= row_d;
      end
   end

   // compute FSM next state and per-cycle enables
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      row_d      = row_q;
      ld_en      = 1'b0;
      mac_en     = 1'b0;
      wb_en      = 1'b0;
      done_pulse = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (cmd_load) begin
               state_d = S_LOADW;
               k_d     = '0;
            end else if (cmd_start) begin
               state_d = S_ROW_MAC;
               k_d     = '0;
               row_d   = '0;
            end
         end
         S_LOADW: begin
            ld_en = 1'b1;
            k_d   = k_q + 1'b1;
            if (k_q == PW'(N-1)) state_d = S_IDLE;
         end
         S_ROW_MAC: begin
            mac_en = 1'b1;
            k_d    = k_q + 1'b1;
            if (k_q == PW'(N-1)) state_d = S_ROW_WB;
         end
         S_ROW_WB: begin
            wb_en = 1'b1;
            k_d   = '0;
            if (row_q == PW'(N-1)) begin
               state_d    = S_DONE;
               done_pulse = 1'b1;
            end else begin
               row_d   = row_q + 1'b1;
               state_d = S_ROW_MAC;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // bias add, activation and int8 saturation for one lane
   function automatic logic [7:0] wb_lane(input logic signed [ACC_W-1:0] acc,
                                          input logic signed [7:0] b,
                                          input logic [1:0] mode);
      logic signed [ACC_W:0] v;
      logic [7:0] r;
      v = {acc[ACC_W-1], acc} + {{(ACC_W-7){b[7]}}, b};
      if (v[ACC_W] && mode == 2'd2)      v = '0;
      else if (v[ACC_W] && mode == 2'd3) v = v >>> 2;
      if (v > SAT_HI)      r = 8'h7f;
      else if (v < SAT_LO) r = 8'h80;
      else                 r = v[7:0];
      return r;
   endfunction

   // lane products, accumulator next values and write-back row
   always_comb begin
      x_k    = ibuf_q[row_q][{k_q, 3'b000} +: 8];
      wb_row = '0;
      for (int j = 0; j < N; j++) begin
         prod[j]  = x_k * $signed(wact_q[k_q][8*j +: 8]);
         acc_d[j] = ((k_q == '0) ? '0 : acc_q[j]) + ACC_W'(prod[j]);
         wb_row[8*j +: 8] = wb_lane(acc_q[j], bias_q[8*j +: 8], mode_q);
      end
   end

   // active weights, accumulators, output buffer and result flag
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         for (int i = 0; i < N; i++) begin
            wact_q[i] <= '0;
            obuf_q[i] <= '0;
            acc_q[i]  <= '0;
         end
         out_valid_q <= 1'b0;
      end else begin
         if (ld_en) wact_q[k_q] <= wbuf_q[k_q];
         if (mac_en) begin
            for (int j = 0; j < N; j++) acc_q[j] <= acc_d[j];
         end
         if (wb_en) obuf_q[row_q] <= wb_row;
         if (cmd_start)       out_valid_q <= 1'b0;
         else if (done_pulse) out_valid_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_final_top_accel.sv
// Bench for final_top_accel: single AHB transfers, result rows checked
// against a queue of expected rows filled when START is issued.
module tb_final_top_accel;

   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        hsel = 1'b0;
   logic [7:0]  haddr = '0;
   logic [1:0]  htrans = '0;
   logic [2:0]  hsize = '0;
   logic        hwrite = 1'b0;
   logic [63:0] hwdata = '0;
   logic [2:0]  hburst = '0;
   logic [63:0] hrdata;
   logic        hresp, hready;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [63:0] sb_q[$];
   logic [63:0] wm [8];
   logic [63:0] xm [8];
   logic [63:0] bm;
   int          mm;

   logic [7:0] w1 [8] = '{8'h02, 8'h01, 8'h03, 8'h03, 8'h01, 8'h02, 8'h02, 8'h01};
   logic [7:0] x1 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h01, 8'h01, 8'h02};
   logic [7:0] o1 [8] = '{8'h14, 8'h23, 8'h32, 8'h41, 8'h14, 8'h14, 8'h14, 8'h23};

   final_top_accel dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .hsel   (hsel),
      .haddr  (haddr),
      .htrans (htrans),
      .hsize  (hsize),
      .hwrite (hwrite),
      .hwdata (hwdata),
      .hburst (hburst),
      .hrdata (hrdata),
      .hresp  (hresp),
      .hready (hready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one single transfer: address phase, then data phase until hready
   task automatic bus(input logic wr, input logic [7:0] a, input logic [2:0] sz,
                      input logic [63:0] wd, output logic [63:0] rd,
                      output logic rsp, output logic rsp_first, output int low);
      int n;
      @(posedge clk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = wd;
      low = 0; n = 0;
      @(negedge clk);
      rsp_first = hresp;
      while (!hready && n < 4) begin
         low++; n++;
         @(negedge clk);
      end
      rd  = hrdata;
      rsp = hresp;
      if (!hready) chk($sformatf("hready_timeout@%h", a), {63'b0, hready}, 64'd1);
   endtask

   task automatic wr(input logic [7:0] a, input logic [2:0] sz, input logic [63:0] d);
      logic [63:0] unused_rd; logic r, unused_rf; int lo;
      bus(1'b1, a, sz, d, unused_rd, r, unused_rf, lo);
      chk($sformatf("wr_okay@%h", a), {63'b0, r}, 64'd0);
      chk($sformatf("wr_nowait@%h", a), 64'(lo), 64'd0);
   endtask

   task automatic rd_chk(input logic [7:0] a, input logic [2:0] sz, input logic [63:0] exp,
                         input string tag);
      logic [63:0] rd; logic r, unused_rf; int unused_lo;
      bus(1'b0, a, sz, 64'd0, rd, r, unused_rf, unused_lo);
      chk(tag, rd, exp);
      chk({tag, "_resp"}, {63'b0, r}, 64'd0);
   endtask

   task automatic err_x(input logic w, input logic [7:0] a, input logic [2:0] sz,
                        input logic [63:0] d, input string tag);
      logic [63:0] unused_rd; logic r, rf; int lo;
      bus(w, a, sz, d, unused_rd, r, rf, lo);
      chk({tag, "_resp1"}, {63'b0, rf}, 64'd1);
      chk({tag, "_resp2"}, {63'b0, r}, 64'd1);
      chk({tag, "_stall"}, 64'(lo), 64'd1);
   endtask

   task automatic poll_idle();
      logic [63:0] rd; logic unused_r, unused_rf; int unused_lo, n;
      rd = 64'd1; n = 0;
      while (rd[0] && n < 60) begin
         bus(1'b0, 8'h20, 3'd0, 64'd0, rd, unused_r, unused_rf, unused_lo);
         n++;
      end
      chk("poll_idle", {63'b0, rd[0]}, 64'd0);
   endtask

   task automatic rd_out(input string tag);
      logic [63:0] rd, exp; logic r, unused_rf; int unused_lo;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         exp = sb_q.pop_front();
         bus(1'b0, 8'h18, 3'd3, 64'd0, rd, r, unused_rf, unused_lo);
         chk(tag, rd, exp);
         chk({tag, "_resp"}, {63'b0, r}, 64'd0);
      end
   endtask

   task automatic read_rows(input string tag);
      for (int i = 0; i < 8; i++) rd_out($sformatf("%s_row%0d", tag, i));
   endtask

   task automatic load_w();
      wr(8'h22, 3'd0, 64'h0000_0000_0002_0000);
      poll_idle();
   endtask

   task automatic start();
      wr(8'h22, 3'd0, 64'h0000_0000_0001_0000);
   endtask

   function automatic logic [63:0] model_row(input int i);
      logic [63:0] r;
      int acc, v;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         acc = 0;
         for (int k = 0; k < 8; k++)
            acc += int'($signed(xm[i][8*k +: 8])) * int'($signed(wm[k][8*j +: 8]));
         v = acc + int'($signed(bm[8*j +: 8]));
         if (v < 0 && mm == 2)      v = 0;
         else if (v < 0 && mm == 3) v = v >>> 2;
         if (v > 127)       v = 127;
         else if (v < -128) v = -128;
         r[8*j +: 8] = 8'(v);
      end
      return r;
   endfunction

   initial begin
      int t0, dt;

      // reset values
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b0;
      @(negedge clk);
      chk("rst_hready", {63'b0, hready}, 64'd1);
      chk("rst_hresp", {63'b0, hresp}, 64'd0);
      chk("rst_hrdata", hrdata, 64'd0);
      rd_chk(8'h20, 3'd0, 64'd0, "st_reset");
      err_x(1'b0, 8'h01, 3'd0, 64'd0, "err_unmapped");

      // test-plan matmul with ReLU and bias 5
      for (int i = 0; i < 8; i++) wr(8'h00, 3'd3, {8{w1[i]}});
      wr(8'h22, 3'd0, 64'h0000_0000_0002_0000);
      rd_chk(8'h20, 3'd0, 64'd1, "st_loadw_busy");
      poll_idle();
      for (int i = 0; i < 8; i++) wr(8'h08, 3'd3, {8{x1[i]}});
      wr(8'h24, 3'd0, 64'h0000_0002_0000_0000);
      wr(8'h10, 3'd3, {8{8'h05}});
      rd_chk(8'h10, 3'd3, {8{8'h05}}, "bias_rd");
      rd_chk(8'h24, 3'd0, 64'h0000_0002_0000_0000, "act_rd");
      start();
      t0 = cyc;
      for (int i = 0; i < 8; i++) sb_q.push_back({8{o1[i]}});
      rd_chk(8'h20, 3'd0, 64'd1, "st_busy");
      err_x(1'b0, 8'h18, 3'd3, 64'd0, "err_out_busy");
      err_x(1'b1, 8'h10, 3'd3, 64'hdead_beef_0000_0000, "err_bias_busy");
      poll_idle();
      dt = cyc - t0;
      chk("latency_window", {63'b0, (dt >= 70 && dt <= 80)}, 64'd1);
      rd_chk(8'h20, 3'd0, 64'd2, "st_done");
      rd_chk(8'h10, 3'd3, {8{8'h05}}, "bias_kept");
      read_rows("plan");
      sb_q.push_back({8{o1[0]}});
      rd_out("out_wrap");

      // protocol errors and CTRL behaviour
      err_x(1'b1, 8'h20, 3'd0, 64'd0, "err_wr_status");
      err_x(1'b1, 8'h18, 3'd3, 64'd0, "err_wr_output");
      err_x(1'b0, 8'h00, 3'd3, 64'd0, "err_rd_weight");
      err_x(1'b0, 8'h08, 3'd3, 64'd0, "err_rd_input");
      err_x(1'b0, 8'h20, 3'd3, 64'd0, "err_size_status");
      err_x(1'b1, 8'h00, 3'd0, 64'd0, "err_size_weight");
      rd_chk(8'h22, 3'd0, 64'd0, "ctrl_rd_zero");
      wr(8'h22, 3'd0, 64'h0000_0000_0003_0000);
      rd_chk(8'h20, 3'd0, 64'd2, "st_after_noop");

      // negative weights: ReLU then identity
      wr(8'h00, 3'd3, {8{8'hff}});
      for (int i = 1; i < 8; i++) wr(8'h00, 3'd3, 64'd0);
      load_w();
      for (int i = 0; i < 8; i++) wr(8'h08, 3'd3, {8{8'h7f}});
      wr(8'h10, 3'd3, 64'd0);
      wr(8'h24, 3'd0, 64'h0000_0002_0000_0000);
      start();
      for (int i = 0; i < 8; i++) sb_q.push_back(64'd0);
      poll_idle();
      read_rows("neg_relu");
      wr(8'h24, 3'd0, 64'd0);
      start();
      for (int i = 0; i < 8; i++) sb_q.push_back({8{8'h81}});
      poll_idle();
      read_rows("neg_ident");

      // saturation, weight write while busy rejected
      for (int i = 0; i < 8; i++) wr(8'h00, 3'd3, {8{8'h7f}});
      load_w();
      for (int i = 0; i < 8; i++) wr(8'h08, 3'd3, {8{8'h7f}});
      wr(8'h10, 3'd3, {8{8'h7f}});
      start();
      err_x(1'b1, 8'h00, 3'd3, 64'd0, "err_wr_w_busy");
      for (int i = 0; i < 8; i++) sb_q.push_back({8{8'h7f}});
      poll_idle();
      read_rows("sat");

      // random operands, leaky activation, checked against the model
      mm = 3;
      bm = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) begin
         wm[i] = {$urandom, $urandom};
         xm[i] = {$urandom, $urandom};
      end
      wr(8'h24, 3'd0, 64'h0000_0003_0000_0000);
      for (int i = 0; i < 8; i++) wr(8'h00, 3'd3, wm[i]);
      load_w();
      for (int i = 0; i < 8; i++) wr(8'h08, 3'd3, xm[i]);
      wr(8'h10, 3'd3, bm);
      start();
      err_x(1'b1, 8'h00, 3'd3, ~wm[0], "err_wr_w_busy2");
      for (int i = 0; i < 8; i++) sb_q.push_back(model_row(i));
      poll_idle();
      read_rows("rand");
      load_w();
      start();
      for (int i = 0; i < 8; i++) sb_q.push_back(model_row(i));
      poll_idle();
      read_rows("rand_reload");

      // reset during compute
      start();
      repeat (10) @(posedge clk);
      #2 n_rst = 1'b1;
      #1;
      chk("midrst_hready", {63'b0, hready}, 64'd1);
      chk("midrst_hresp", {63'b0, hresp}, 64'd0);
      @(posedge clk); #1 n_rst = 1'b0;
      rd_chk(8'h20, 3'd0, 64'd0, "midrst_status");
      rd_chk(8'h10, 3'd3, 64'd0, "midrst_bias");
      rd_chk(8'h24, 3'd0, 64'd0, "midrst_act");
      rd_chk(8'h18, 3'd3, 64'd0, "midrst_out");

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/final_top_accel.md
Name: final_top_accel

Overview:
- AHB-Lite subordinate wrapping an 8x8 int8 matrix-multiply accelerator: OUT = act(X·W + bias).
- The SoC core writes weight rows and input rows through FIFO-style ports, loads weights, starts compute, and pops result rows.
- Sits on the 64-bit system bus behind the interconnect decoder (hsel).

Parameters:
- N, 8, matrix dimension (rows/cols; one row = N bytes = 64 bits).
- ACC_W, 24, signed accumulator width per lane.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset; asynchronous, active-high.
- hsel  in  1  subordinate select.
- haddr  in  8  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hsize  in  3  0=byte, 3=doubleword.
- hwrite  in  1  1=write.
- hwdata  in  64  write data, valid in data phase.
- hburst  in  3  ignored; every beat handled as an independent single.
- hrdata  out  64  read data.
- hresp  out  1  1=ERROR.
- hready  out  1  transfer complete.

Behaviour:
- Reset: all buffers, pointers, bias, ACT_MODE and flags cleared; hrdata=0, hresp=0, hready=1.
- Transfer acceptance:
  - Active transfer = hsel & hready & htrans[1].
  - Address-phase fields are registered; the action happens in the data phase.
  - OKAY responses have zero wait states.
  - hrdata is driven combinationally from the registered address during the data phase.
- Byte lanes:
  - Row byte j occupies bits [8j+7:8j].
  - Byte registers use the lane selected by haddr[2:0]; read data is placed on the same lane.
- Register map:
  - 0x00 WEIGHT (W, size 3): write stores row at weight write pointer wwp (3-bit, wraps 7->0).
  - 0x08 INPUT (W, size 3): write stores row at input write pointer iwp (wraps).
  - 0x10 BIAS (R/W, size 3): byte j = signed bias for output column j.
  - 0x18 OUTPUT (R, size 3): returns output row at rp, then rp++ (wraps).
  - 0x20 STATUS (R, byte): bit0 = busy, bit1 = out_valid.
  - 0x22 CTRL (W, byte):
    - 2 = LOAD_W: copy weight buffer to active array, 8 cycles busy, wwp cleared.
    - 1 = START.
    - Other values: no-op. Self-clearing; reads return 0.
  - 0x24 ACT_MODE (R/W, byte): 0/1 = identity, 2 = ReLU, 3 = leaky (neg >>> 2).
- ERROR response, two cycles (cycle 1: hready=0, hresp=1; cycle 2: hready=1, hresp=1), no side effects, for any of:
  - unmapped address;
  - wrong hsize;
  - write to OUTPUT/STATUS;
  - read of WEIGHT/INPUT;
  - WEIGHT/INPUT/BIAS/CTRL write while busy;
  - OUTPUT read while busy.
- Compute FSM: IDLE -> LOADW (8 cycles) -> IDLE; IDLE -> ROW_MAC -> ROW_WB -> next row or DONE -> IDLE.
- START sequence:
  - busy=1, out_valid=0.
  - For each row i=0..7: 8 MAC cycles, acc[j] += X[i][k]*W[k][j] (signed int8 x int8, all 8 lanes in parallel).
  - Write-back cycle: v = acc[j] + bias[j], apply ACT_MODE, saturate to [-128,127], store into output row i.
  - Total latency 72 cycles. Then busy=0, out_valid=1, iwp=0, rp=0.
- START issued during LOADW or compute is ignored.
- n_rst mid-operation aborts to IDLE, clears everything.

Test Plan:
- Reset, read 0x20 -> 0x00; read 0x01 byte -> ERROR two-cycle response, hready low exactly 1 cycle.
- Write WEIGHT rows 0x02,0x01,0x03,0x03,0x01,0x02,0x02,0x01 (each byte replicated); CTRL=2; poll STATUS until busy=0.
- Write INPUT rows 0x01,0x02,0x03,0x04,0x01,0x01,0x01,0x02; ACT_MODE=2; BIAS=0x0505…05; CTRL=1; within 80 cycles STATUS -> 0x02.
- Eight OUTPUT reads return 0x14…14, 0x23…23, 0x32…32, 0x41…41, 0x14…14, 0x14…14, 0x14…14, 0x23…23; ninth read wraps to 0x14…14.
- Negative path: W row0 = 0xFF (-1) in all bytes, others 0, X all 0x7F, bias 0, mode 2 -> rows 0x00…00; mode 0 -> 0x81…81 (-127).
- Saturation: W and X all 0x7F, bias 0x7F -> all output bytes 0x7F. Write to 0x00 while busy -> ERROR, buffer unchanged.
